// File: rtl/shift_seq.sv
// Sequenced shift register: loads a value in parallel, then runs a counted
// burst of shifts or rotates. busy covers the burst, and done pulses for one
// cycle after the last shift.
module shift_seq #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] data,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic [2:0]           mode,
  input  logic                 bit_in,
  output logic [BIT_WIDTH-1:0] q,
  output logic                 bit_out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned MSB = BIT_WIDTH - 1;

  localparam logic [2:0] MODE_SHR = 3'b000;
  localparam logic [2:0] MODE_SHL = 3'b001;
  localparam logic [2:0] MODE_ROR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
  logic [2:0]             mode_q,  mode_d;
  logic [BIT_WIDTH-1:0]   q_q,     q_d;
  logic                   bit_out_q, bit_out_d;
  logic                   done_q,  done_d;

  // Result of a single step in the latched mode. Modes 101-111 hold.
  logic [BIT_WIDTH-1:0]   shift_q_c;
  logic                   shift_bo_c;

  // One-step shift and rotate datapath
  always_comb begin
    shift_q_c  = q_q;
    shift_bo_c = bit_out_q;
    case (mode_q)
      MODE_SHR: begin
        shift_q_c  = {bit_in, q_q[MSB:1]};
        shift_bo_c = q_q[0];
      end
      MODE_SHL: begin
        shift_q_c  = {q_q[MSB-1:0], bit_in};
        shift_bo_c = q_q[MSB];
      end
      MODE_ROR: begin
        shift_q_c  = {q_q[0], q_q[MSB:1]};
        shift_bo_c = q_q[0];
      end
      MODE_ROL: begin
        shift_q_c  = {q_q[MSB-1:0], q_q[MSB]};
        shift_bo_c = q_q[MSB];
      end
      MODE_ASR: begin
        shift_q_c  = {q_q[MSB], q_q[MSB:1]};
        shift_bo_c = q_q[0];
      end
      default: begin
        shift_q_c  = q_q;
        shift_bo_c = bit_out_q;
      end
    endcase
  end

  // Next-state and next-output logic for the IDLE/SHIFT sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    q_d       = q_q;
    bit_out_d = bit_out_q;
    done_d    = 1'b0;

    if (state_q == IDLE) begin
      // load has priority over start when both are requested together
      if (load) begin
        q_d = data;
      end else if (start) begin
        if (count != '0) begin
          cnt_d   = count;
          mode_d  = mode;
          state_d = SHIFT;
        end else begin
          // A zero-length burst finishes immediately
          done_d = 1'b1;
        end
      end
    end else begin
      // Control inputs are ignored here; only bit_in feeds the datapath
      q_d       = shift_q_c;
      bit_out_d = shift_bo_c;
      cnt_d     = cnt_q - CNT_WIDTH'(1);
      if (cnt_q == CNT_WIDTH'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      q_q       <= '0;
      bit_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      q_q       <= q_d;
      bit_out_q <= bit_out_d;
      done_q    <= done_d;
    end
  end

  assign q       = q_q;
  assign bit_out = bit_out_q;
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: a cycle-by-cycle vector table, followed by a few
// hand-driven multi-cycle sequences.
module tb_shift_seq;

  localparam int unsigned BW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned NV = 29;

  logic          clock;
  logic          reset;
  logic          load;
  logic [BW-1:0] data;
  logic          start;
  logic [CW-1:0] count;
  logic [2:0]    mode;
  logic          bit_in;
  logic [BW-1:0] q;
  logic          bit_out;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  shift_seq #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .data    (data),
    .start   (start),
    .count   (count),
    .mode    (mode),
    .bit_in  (bit_in),
    .q       (q),
    .bit_out (bit_out),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Each record holds the inputs for one cycle and the outputs expected after that edge.
  typedef struct {
    logic          rst;
    logic          ld;
    logic [BW-1:0] d;
    logic          st;
    logic [CW-1:0] cnt;
    logic [2:0]    md;
    logic          bi;
    logic [BW-1:0] eq;
    logic          ebo;
    logic          ebusy;
    logic          edone;
  } vec_t;

  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; load = 1'b0; data = '0; start = 1'b0;
    count = '0; mode = 3'b000; bit_in = 1'b0;
  endtask

  // Start a burst, wait a bounded time for done, then check the result and busy length.
  task automatic run_seq(input string name, input logic [CW-1:0] c, input logic [2:0] m,
                         input logic bi, input logic [BW-1:0] exp_q, input logic exp_bo);
    int n;
    int busy_cycles;
    @(negedge clock);
    start = 1'b1; count = c; mode = m; bit_in = bi;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    busy_cycles = 0;
    while (!done && n < 64) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      n++;
    end
    check({name, " done seen"}, 32'(done), 32'(1));
    check({name, " q"}, 32'(q), 32'(exp_q));
    check({name, " bit_out"}, 32'(bit_out), 32'(exp_bo));
    check({name, " busy cycles"}, 32'(busy_cycles), 32'(c));
    check({name, " busy at done"}, 32'(busy), 32'(0));
    bit_in = 1'b0;
  endtask

  initial begin
    int done_seen;

    // rst ld data st cnt md bi | q bo busy done
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    // right shift, bit_in=1: A5 -> D2
    tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 4'd0, 3'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 3'd0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b1, 8'hD2, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'hD2, 1'b1, 1'b0, 1'b0};
    // rotate left 3: 81 -> 03 -> 06 -> 0C; bit_out holds across load
    tbl[5]  = '{1'b0, 1'b1, 8'h81, 1'b0, 4'd0, 3'd0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 3'd3, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'h06, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b1};
    // arithmetic right 2: 90 -> C8 -> E4
    tbl[10] = '{1'b0, 1'b1, 8'h90, 1'b0, 4'd0, 3'd0, 1'b0, 8'h90, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd2, 3'd4, 1'b0, 8'h90, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'hE4, 1'b0, 1'b0, 1'b1};
    // zero count: done only, no busy, q unchanged
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 3'd0, 1'b1, 8'hE4, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'hE4, 1'b0, 1'b0, 1'b0};
    // shift left 3 while load/start are pulsed mid-burst: 3C -> 79 -> F2 -> E5
    tbl[16] = '{1'b0, 1'b1, 8'h3C, 1'b0, 4'd0, 3'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 3'd1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 3'd0, 1'b1, 8'h79, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 3'd0, 1'b0, 8'hF2, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b1, 8'hE5, 1'b1, 1'b0, 1'b1};
    // start during the done cycle is accepted: rotate right 2, E5 -> F2 -> 79
    tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd2, 3'd2, 1'b0, 8'hE5, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'hF2, 1'b1, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'h79, 1'b0, 1'b0, 1'b1};
    // load and start together: load wins
    tbl[24] = '{1'b0, 1'b1, 8'h5A, 1'b1, 4'd2, 3'd0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    // reserved mode 101: hold q and bit_out, count still elapses
    tbl[26] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd2, 3'd5, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
    tbl[27] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
    tbl[28] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1};

    drive_idle();
    reset = 1'b1;

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clock);
      reset = tbl[i].rst; load = tbl[i].ld; data = tbl[i].d; start = tbl[i].st;
      count = tbl[i].cnt; mode = tbl[i].md; bit_in = tbl[i].bi;
      @(posedge clock);
      #1;
      check($sformatf("v%0d q", i), 32'(q), 32'(tbl[i].eq));
      check($sformatf("v%0d bit_out", i), 32'(bit_out), 32'(tbl[i].ebo));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].ebusy));
      check($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].edone));
    end
    @(negedge clock);
    drive_idle();

    // Counts beyond the width: 9 rotates right of 5A equal one rotate -> 2D
    run_seq("ror9", 4'd9, 3'd2, 1'b0, 8'h2D, 1'b0);
    // 10 logical right shifts with bit_in=1 fill completely with ones
    run_seq("shr10", 4'd10, 3'd0, 1'b1, 8'hFF, 1'b1);

    // Reset in the middle of a burst aborts it without a done pulse
    @(negedge clock);
    load = 1'b1; data = 8'hFF;
    @(negedge clock);
    load = 1'b0; start = 1'b1; count = 4'd8; mode = 3'd0; bit_in = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("abort q before reset", 32'(q), 32'(8'h1F));
    check("abort busy before reset", 32'(busy), 32'(1));
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort q", 32'(q), 32'(0));
    check("abort bit_out", 32'(bit_out), 32'(0));
    check("abort busy", 32'(busy), 32'(0));
    check("abort done", 32'(done), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (done || busy) done_seen++;
    end
    check("abort quiet after reset", 32'(done_seen), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
